// File: rtl/obi_host_mem.sv
// obi_host_mem: word-organised host memory behind an OBI slave port.
// Zero-wait-state grant and a fixed LATENCY-deep response pipeline.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   req_i     request valid
//   we_i      1 = write, 0 = read
//   be_i      byte enables, bit n covers wdata_i[8n+7:8n]
//   addr_i    byte address (wraps modulo MEM_SIZE_WORD words)
//   wdata_i   write data
//   gnt_o     grant, combinational
//   rvalid_o  response valid, one pulse per granted request
//   rdata_o   read data (0 for write responses and when idle)
module obi_host_mem #(
    parameter int unsigned MEM_SIZE_WORD = 32768,
    parameter int unsigned LATENCY       = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned AW = $clog2(MEM_SIZE_WORD);

    if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
        $error("obi_host_mem: LATENCY must be 1..4");
    end
    if ((1 << AW) != MEM_SIZE_WORD) begin : g_bad_size
        $error("obi_host_mem: MEM_SIZE_WORD must be a power of two");
    end

    // Preloaded and dumped by hierarchical reference; never reset.
    logic [31:0] mem_array [MEM_SIZE_WORD];

    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx         = addr_i[AW+1:2];
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
    assign gnt_o       = req_i & ~rst_i;

    // Byte-lane write at the grant edge.
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_array[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline. Stage 0 is loaded at the grant edge, so the
    // last stage presents the response LATENCY cycles later. Idle
    // stages carry zero data so rdata_o is 0 whenever rvalid_o is 0.
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [31:0]        data_q [LATENCY];
    logic [31:0]        data_d [LATENCY];

    always_comb begin
        valid_d    = '0;
        for (int i = 0; i < LATENCY; i++) begin
            data_d[i] = '0;
        end
        valid_d[0] = gnt_o;
        // The read sees the array before any same-edge write, which
        // cannot collide because only one request is taken per cycle.
        if (gnt_o && !we_i) begin
            data_d[0] = mem_array[idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign rvalid_o = valid_q[LATENCY-1];
    assign rdata_o  = data_q[LATENCY-1];

endmodule

// File: tb/tb_obi_host_mem.sv
// tb_obi_host_mem: drives two obi_host_mem instances (LATENCY 1 and 3)
// with shared stimulus and checks them against a queue-based model.
module tb_obi_host_mem;

    localparam int unsigned MEMW = 32768;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt1, gnt3;
    logic        rv1, rv3;
    logic [31:0] rd1, rd3;

    obi_host_mem #(.MEM_SIZE_WORD(MEMW), .LATENCY(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt1),
        .rvalid_o(rv1), .rdata_o(rd1)
    );

    obi_host_mem #(.MEM_SIZE_WORD(MEMW), .LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt3),
        .rvalid_o(rv3), .rdata_o(rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic        rs;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] wd;
    } op_t;

    logic [31:0] mem_m [MEMW];
    rsp_t        q1[$];
    rsp_t        q3[$];
    int          n;
    int          vectors;
    int          miscompares;

    logic [1:0]  exp_gnt, obs_gnt;
    logic [65:0] exp_rsp, obs_rsp;

    function automatic op_t mk(input logic r, input logic w,
                               input logic [3:0] b, input logic [31:0] a,
                               input logic [31:0] wd, input logic rs);
        op_t o;
        o.r = r; o.w = w; o.b = b; o.a = a; o.wd = wd; o.rs = rs;
        return o;
    endfunction

    function automatic op_t idle_op();
        return mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endfunction

    task automatic bd_write(input int unsigned ix, input logic [31:0] v);
        dut.mem_array[ix]  = v;
        dut3.mem_array[ix] = v;
        mem_m[ix]          = v;
    endtask

    // One clock of stimulus; updates the model and captures both the
    // expected and observed grant and response for the caller to compare.
    task automatic step(input op_t o);
        int unsigned ix;
        logic [31:0] d;
        logic        ev1, ev3;
        logic [31:0] ed1, ed3;
        @(negedge clk);
        req = o.r; we = o.w; be = o.b; addr = o.a; wdata = o.wd; rst = o.rs;
        #1;
        obs_gnt = {gnt1, gnt3};
        exp_gnt = {2{o.r & ~o.rs}};
        @(posedge clk);
        n++;
        if (o.rs) begin
            q1.delete();
            q3.delete();
        end else if (o.r) begin
            ix = (o.a >> 2) % MEMW;
            d  = o.w ? 32'h0 : mem_m[ix];
            if (o.w) begin
                for (int k = 0; k < 4; k++) begin
                    if (o.b[k]) mem_m[ix][8*k +: 8] = o.wd[8*k +: 8];
                end
            end
            q1.push_back('{due: n, d: d});
            q3.push_back('{due: n + 2, d: d});
        end
        #1;
        ev1 = 1'b0; ed1 = 32'h0; ev3 = 1'b0; ed3 = 32'h0;
        if (q1.size() > 0 && q1[0].due == n) begin
            ev1 = 1'b1; ed1 = q1[0].d; void'(q1.pop_front());
        end
        if (q3.size() > 0 && q3[0].due == n) begin
            ev3 = 1'b1; ed3 = q3[0].d; void'(q3.pop_front());
        end
        exp_rsp = {ev1, ed1, ev3, ed3};
        obs_rsp = {rv1, rd1, rv3, rd3};
    endtask

    task automatic test_reset();
        op_t ops[$];
        for (int i = 0; i < 64; i++) bd_write(i, $urandom);
        for (int i = 0; i < 4; i++) begin
            bd_write(32'h4000 + i, $urandom);
            bd_write(32'h6000 + i, $urandom);
        end
        bd_write(32'h4000, 32'hDEADBEEF);
        // Requests during reset, including a write, must be ignored.
        ops.push_back(mk(1, 0, 4'hF, 32'h10000, 32'h0, 1));
        ops.push_back(mk(1, 1, 4'hF, 32'h0, 32'hCAFEF00D, 1));
        ops.push_back(mk(0, 0, 4'h0, 32'h0, 32'h0, 1));
        foreach (ops[i]) begin
            step(ops[i]);
            vectors++;
            if (obs_gnt !== exp_gnt) begin
                miscompares++;
                $display("FAIL reset_gnt[%0d] got %b want %b", i, obs_gnt, exp_gnt);
            end
            vectors++;
            if (obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL reset_rsp[%0d] got %h want %h", i, obs_rsp, exp_rsp);
            end
        end
        vectors++;
        if (dut.mem_array[0] !== mem_m[0] || dut.mem_array[32'h4000] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL reset_mem got %h/%h want %h/%h", dut.mem_array[0],
                     dut.mem_array[32'h4000], mem_m[0], 32'hDEADBEEF);
        end
    endtask

    task automatic test_read_preload();
        op_t ops[$];
        ops.push_back(mk(1, 0, 4'h0, 32'h10000, 32'h0, 0));
        for (int i = 0; i < 3; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            vectors++;
            if (obs_gnt !== exp_gnt || obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL read_preload[%0d] got %b/%h want %b/%h",
                         i, obs_gnt, obs_rsp, exp_gnt, exp_rsp);
            end
        end
    endtask

    task automatic test_write_read();
        op_t ops[$];
        ops.push_back(mk(1, 1, 4'hF, 32'h18000, 32'h11223344, 0));
        ops.push_back(mk(1, 0, 4'h0, 32'h18000, 32'h0, 0));
        for (int i = 0; i < 3; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            vectors++;
            if (obs_gnt !== exp_gnt || obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL write_read[%0d] got %b/%h want %b/%h",
                         i, obs_gnt, obs_rsp, exp_gnt, exp_rsp);
            end
        end
    endtask

    task automatic test_partial();
        op_t ops[$];
        ops.push_back(mk(1, 1, 4'hF, 32'h18004, 32'hAABBCCDD, 0));
        ops.push_back(mk(1, 1, 4'h1, 32'h18004, 32'h00000099, 0));
        ops.push_back(mk(1, 0, 4'h0, 32'h18004, 32'h0, 0));
        ops.push_back(mk(1, 1, 4'h8, 32'h18004, 32'h55000000, 0));
        ops.push_back(mk(1, 1, 4'h0, 32'h18004, 32'hFFFFFFFF, 0));
        ops.push_back(mk(1, 0, 4'h0, 32'h18004, 32'h0, 0));
        for (int i = 0; i < 3; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            vectors++;
            if (obs_gnt !== exp_gnt || obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL partial[%0d] got %b/%h want %b/%h",
                         i, obs_gnt, obs_rsp, exp_gnt, exp_rsp);
            end
        end
        vectors++;
        if (mem_m[32'h6001] !== 32'h55BBCC99 || dut3.mem_array[32'h6001] !== 32'h55BBCC99) begin
            miscompares++;
            $display("FAIL partial_word got %h want %h", dut3.mem_array[32'h6001], 32'h55BBCC99);
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        int  pulses;
        pulses = 0;
        ops.push_back(mk(1, 0, 4'h0, 32'h0, 32'h0, 0));
        ops.push_back(mk(1, 0, 4'h0, 32'h4, 32'h0, 0));
        ops.push_back(mk(1, 0, 4'h0, 32'h8, 32'h0, 0));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            if (rv3 === 1'b1) pulses++;
            vectors++;
            if (obs_gnt !== exp_gnt || obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL b2b[%0d] got %b/%h want %b/%h",
                         i, obs_gnt, obs_rsp, exp_gnt, exp_rsp);
            end
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL b2b_pulses got %0d want 3", pulses);
        end
    endtask

    task automatic test_wrap_reset();
        op_t         ops[$];
        logic [31:0] snap0, snap1;
        ops.push_back(mk(1, 0, 4'h0, 32'h00020000, 32'h0, 0));
        ops.push_back(mk(1, 0, 4'h0, 32'hFFFE0007, 32'h0, 0));
        ops.push_back(idle_op());
        ops.push_back(idle_op());
        ops.push_back(idle_op());
        ops.push_back(mk(1, 0, 4'h0, 32'h8, 32'h0, 0));
        ops.push_back(mk(1, 1, 4'hF, 32'h0, 32'h12345678, 1));
        ops.push_back(mk(0, 0, 4'h0, 32'h0, 32'h0, 1));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        snap0 = mem_m[0];
        snap1 = mem_m[1];
        foreach (ops[i]) begin
            step(ops[i]);
            vectors++;
            if (obs_gnt !== exp_gnt || obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL wrap_reset[%0d] got %b/%h want %b/%h",
                         i, obs_gnt, obs_rsp, exp_gnt, exp_rsp);
            end
        end
        vectors++;
        if (dut.mem_array[0] !== snap0 || dut3.mem_array[1] !== snap1) begin
            miscompares++;
            $display("FAIL wrap_mem got %h/%h want %h/%h",
                     dut.mem_array[0], dut3.mem_array[1], snap0, snap1);
        end
    endtask

    task automatic test_random();
        op_t o;
        for (int i = 0; i < 400; i++) begin
            o.r  = ($urandom_range(0, 3) != 0);
            o.w  = $urandom_range(0, 1);
            o.b  = $urandom;
            o.a  = ($urandom & 32'hFFFE0000) | ($urandom_range(0, 63) << 2) | ($urandom & 3);
            o.wd = $urandom;
            o.rs = ($urandom_range(0, 40) == 0);
            step(o);
            vectors++;
            if (obs_gnt !== exp_gnt || obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL random[%0d] got %b/%h want %b/%h",
                         i, obs_gnt, obs_rsp, exp_gnt, exp_rsp);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(idle_op());
            vectors++;
            if (obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL random_drain[%0d] got %h want %h", i, obs_rsp, exp_rsp);
            end
        end
        for (int i = 0; i < 64; i++) begin
            vectors++;
            if (dut.mem_array[i] !== mem_m[i] || dut3.mem_array[i] !== mem_m[i]) begin
                miscompares++;
                $display("FAIL random_mem[%0d] got %h/%h want %h",
                         i, dut.mem_array[i], dut3.mem_array[i], mem_m[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0;
        addr = 32'h0; wdata = 32'h0;
        n = 0; vectors = 0; miscompares = 0;
        test_reset();
        test_read_preload();
        test_write_read();
        test_partial();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
